// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow/active digit buffers swap only at frame end.
// Outputs are registered one clock behind the scan index; optional hex glyphs, leading-zero blanking, pin inversion.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 27000,
  parameter int HEX_EN      = 0,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_pulse
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   shadow;
  logic [4*NUM_DIGITS-1:0]   active;
  logic                      tc;
  logic                      frame_end;
  logic [3:0]                cur_nib;
  logic                      cur_blank;
  logic                      higher_zero;
  logic [6:0]                seg_log;
  logic [NUM_DIGITS-1:0]     an_log;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1110011;
      4'd10:   g = (HEX_EN != 0) ? 7'b1110111 : 7'b0000001;
      4'd11:   g = (HEX_EN != 0) ? 7'b0011111 : 7'b0000001;
      4'd12:   g = (HEX_EN != 0) ? 7'b1001110 : 7'b0000001;
      4'd13:   g = (HEX_EN != 0) ? 7'b0111101 : 7'b0000001;
      4'd14:   g = (HEX_EN != 0) ? 7'b1001111 : 7'b0000001;
      default: g = (HEX_EN != 0) ? 7'b1000111 : 7'b0000001;
    endcase
    return g;
  endfunction

  assign tc        = (cnt == CNT_LAST);
  assign frame_end = tc && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tc) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load coinciding with the frame end bypasses the shadow so it is not lost for a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load) shadow <= digits_in;
      if (frame_end) active <= load ? digits_in : shadow;
    end
  end

  // Scan from the top digit down so "this and all higher digits are zero" accumulates naturally.
  always_comb begin
    cur_nib     = '0;
    cur_blank   = 1'b0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (active[4*i +: 4] == 4'd0);
      if (i == int'(idx)) begin
        cur_nib   = active[4*i +: 4];
        cur_blank = blank_lz && (i != 0) && higher_zero;
      end
    end
  end

  always_comb begin
    seg_log     = cur_blank ? 7'b0000000 : glyph(cur_nib);
    an_log      = '0;
    an_log[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segments    <= SEG_POL;
      an          <= AN_POL;
      frame_pulse <= 1'b0;
    end else begin
      segments    <= seg_log ^ SEG_POL;
      an          <= an_log ^ AN_POL;
      frame_pulse <= frame_end;
    end
  end

endmodule
